// File: rtl/lsu_mem_initiator_if.sv
// rtl/lsu_mem_initiator_if.sv - request/response and memory-side signal bundle for lsu_mem_initiator
interface lsu_mem_initiator_if #(
    parameter int IDX_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    // Requester side (datapath plus memory model)
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - byte-addressed load/store initiator for a word memory (optional: LSU_ERR_COUNT_EN)
module lsu_mem_initiator #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_initiator_if.slave bus
`ifdef LSU_ERR_COUNT_EN
    ,
    output logic [7:0]         err_count
`endif
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              acc_err;
    logic              we_q;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wbuf_q;
    logic [DATA_W-1:0] rdata_q;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merge_val;

    assign accept = bus.req_valid && (state == IDLE);

    // Reject reserved size, misaligned half/word and addresses past the last word
    always_comb begin
        acc_err = 1'b0;
        case (bus.req_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = bus.req_addr[0];
            2'b10:   acc_err = (bus.req_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if ((bus.req_addr >> (IDX_W + 2)) != 32'd0) begin
            acc_err = 1'b1;
        end
    end

    // State register; async reset also kills an in-flight write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: word stores skip the read, sub-word stores read first (RMW)
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_err) begin
                        state_nx = RESP;
                    end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Lane extraction with extension for loads, lane merge for sub-word stores
    always_comb begin
        byte_sel = bus.mem_rd[{lane_q, 3'b000} +: 8];
        half_sel = bus.mem_rd[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{24{sgn_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{sgn_q & half_sel[15]}}, half_sel};
            default: load_val = bus.mem_rd;
        endcase
        merge_val = bus.mem_rd;
        if (size_q == 2'b00) begin
            merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Request capture, read-phase results and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            wdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        sgn_q   <= bus.req_signed;
                        size_q  <= bus.req_size;
                        lane_q  <= bus.req_addr[1:0];
                        wdata_q <= bus.req_wdata[15:0];
                        err_q   <= acc_err;
                        rdata_q <= '0;
                        // mem_a only moves for real accesses
                        if (!acc_err) begin
                            idx_q <= bus.req_addr[IDX_W+1:2];
                        end
                        if (!acc_err && bus.req_we && (bus.req_size == 2'b10)) begin
                            wbuf_q <= bus.req_wdata;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        wbuf_q <= merge_val;
                    end else begin
                        rdata_q <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_ERR_COUNT_EN
    // Saturating count of accepted requests that were flagged as errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (accept && acc_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_we    = (state == WR);
    assign bus.mem_a     = idx_q;
    assign bus.mem_wd    = wbuf_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - vector table, random reference-model and reset checks for lsu_mem_initiator
module tb_lsu_mem_initiator;
    localparam int IDX_W = 8;
    localparam int DEPTH = 1 << IDX_W;
    localparam int NBYTES = DEPTH * 4;

    logic clk;
    logic rst_n;
    lsu_mem_initiator_if #(.IDX_W(IDX_W)) bus();

`ifdef LSU_ERR_COUNT_EN
    logic [7:0] err_count;
    lsu_mem_initiator #(.IDX_W(IDX_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .err_count(err_count));
`else
    lsu_mem_initiator #(.IDX_W(IDX_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT
    logic [31:0] mem [0:DEPTH-1];
    int          wp_count;
    logic [IDX_W-1:0] last_wa;
    logic [31:0] last_wd;
    assign bus.mem_rd = mem[bus.mem_a];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_a] <= bus.mem_wd;
            wp_count       <= wp_count + 1;
            last_wa        <= bus.mem_a;
            last_wd        <= bus.mem_wd;
        end
    end

    // Reference model: flat byte array, accesses computed from size/alignment rules
    logic [7:0] ref_bytes [0:NBYTES-1];
    int         ref_err_cnt;

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_access(input logic we, input logic [1:0] size, input logic sgn,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err,
                                       output int lat, output int wp);
        int nb;
        logic [63:0] v;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % nb) != 0) || (addr >= NBYTES);
        rd  = 32'd0;
        if (err) begin
            lat = 1;
            wp  = 0;
            if (ref_err_cnt < 255) ref_err_cnt++;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_bytes[addr + i] = wd[8*i +: 8];
            lat = (nb == 4) ? 2 : 3;
            wp  = 1;
        end else begin
            v = 64'd0;
            for (int i = 0; i < nb; i++) v = v | (64'(ref_bytes[addr + i]) << (8 * i));
            if (sgn && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
            rd  = v[31:0];
            lat = 2;
            wp  = 0;
        end
    endfunction

    // One transaction; called at #1 after a rising edge with the unit idle
    task automatic xact(input string name, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic err, output int lat, output int wp);
        int wp0;
        wp0 = wp_count;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no rsp_valid expected rsp_valid within 20 edges", name);
        end
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        // Hold off the response; a competing request must not be taken
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            check({name, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({name, "_hold_rdata"}, bus.rsp_rdata, rd);
            check({name, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        if (hold > 0) begin
            check({name, "_after_hs_idle"}, 32'(bus.req_ready), 32'd1);
        end
        wp = wp_count - wp0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, m_rd;
        logic        err, m_err;
        int          lat, m_lat, wp, m_wp, bad;
        logic [31:0] a;
        logic [1:0]  sz;

        n_tests = 0;
        n_fail  = 0;
        wp_count = 0;
        ref_err_cnt = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
        for (int i = 0; i < NBYTES; i++) ref_bytes[i] = 8'd0;

        //        we    size  sgn   addr          wdata         hold rdata         err   lat
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1122_3344, 0, 32'h0000_0000, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_0012, 32'h0000_00AB, 0, 32'h0000_0000, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         0, 32'h11AB_3344, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0000_80F0, 0, 32'h0000_0000, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,         0, 32'hFFFF_80F0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0,         0, 32'h0000_80F0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'h0,         0, 32'hFFFF_FFF0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0,         0, 32'h0000_0080, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,         0, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h1234_5678, 0, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0,         0, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         0, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h1234_CAFE, 2, 32'h0000_0000, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         0, 32'hCAFE_80F0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,         0, 32'hFFFF_CAFE, 1'b0, 2});

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_mem_a",     32'(bus.mem_a), 32'd0);
        check("rst_mem_wd",    bus.mem_wd, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            ref_access(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                       m_rd, m_err, m_lat, m_wp);
            xact($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                 vecs[i].wdata, vecs[i].hold, rd, err, lat, wp);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_wpulses", i), 32'(wp), (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
            if (i == 0) begin
                check("vec0_mem_a",  32'(last_wa), 32'd4);
                check("vec0_mem_wd", last_wd, 32'hDEAD_BEEF);
            end
        end
`ifdef LSU_ERR_COUNT_EN
        check("err_count_table", 32'(err_count), 32'd4);
`endif

        // Randomized traffic against the byte-level reference model
        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(IDX_W + 2, 31));
            else if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd2) ? 32'd3 : (sz == 2'd1) ? 32'd1 : 32'd0);
            begin
                logic        r_we, r_sg;
                logic [31:0] r_wd;
                int          r_hold;
                r_we = 1'($urandom_range(0, 1));
                r_sg = 1'($urandom_range(0, 1));
                r_wd = $urandom;
                r_hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
                ref_access(r_we, sz, r_sg, a, r_wd, m_rd, m_err, m_lat, m_wp);
                xact($sformatf("rnd%0d", i), r_we, sz, r_sg, a, r_wd, r_hold, rd, err, lat, wp);
            end
            check($sformatf("rnd%0d_rdata", i), rd, m_rd);
            check($sformatf("rnd%0d_err", i), 32'(err), 32'(m_err));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d_wpulses", i), 32'(wp), 32'(m_wp));
        end

        bad = 0;
        for (int w = 0; w < DEPTH; w++) begin
            if (mem[w] !== {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]}) bad++;
        end
        check("mem_final_bad_words", 32'(bad), 32'd0);
`ifdef LSU_ERR_COUNT_EN
        check("err_count_rand", 32'(err_count), 32'(ref_err_cnt));
`endif

        // Reset while a word store is in its write cycle
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0000_0020; bus.req_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("mid_wr_mem_we", 32'(bus.mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
`ifdef LSU_ERR_COUNT_EN
        check("rst_mid_err_count", 32'(err_count), 32'd0);
`endif
        ref_access(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0, m_rd, m_err, m_lat, m_wp);
        xact("post_rst_load", 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0, 0, rd, err, lat, wp);
        check("post_rst_rdata", rd, m_rd);
        check("post_rst_err",   32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench cannot hang
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end
endmodule
